// File: rtl/bp_be_dcache_uc_store_buffer.sv
// Uncached store buffer: circular FIFO of replicated store payloads in front of
// the LCE request handler, with a credit counter bounding in-flight uc writes.
module bp_be_dcache_uc_store_buffer #(
  parameter int paddr_width_p = 40,
  parameter int dword_width_p = 64,
  parameter int els_p         = 4,
  parameter int credits_p     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,

  input  logic                     st_v_i,
  input  logic [paddr_width_p-1:0] st_addr_i,
  input  logic [1:0]               st_size_i,
  input  logic [dword_width_p-1:0] st_data_i,
  output logic                     st_ready_o,

  output logic                     st_v_o,
  output logic [paddr_width_p-1:0] st_addr_o,
  output logic [1:0]               st_size_o,
  output logic [dword_width_p-1:0] st_data_o,
  input  logic                     st_yumi_i,

  input  logic                     credit_return_i,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);
  localparam int crd_w = $clog2(credits_p + 1);

  logic [paddr_width_p-1:0] addr_mem_q [els_p];
  logic [1:0]               size_mem_q [els_p];
  logic [dword_width_p-1:0] data_mem_q [els_p];

  logic [ptr_w-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_w-1:0] count_q, count_d;
  logic [crd_w-1:0] outstanding_q, outstanding_d;

  logic                     enq, deq, misaligned;
  logic [dword_width_p-1:0] rep_data;

  assign st_ready_o = (count_q != cnt_w'(els_p));
  assign st_v_o     = (count_q != '0) && (outstanding_q != crd_w'(credits_p));
  assign full_o     = (count_q == cnt_w'(els_p));
  assign empty_o    = (count_q == '0) && (outstanding_q == '0);

  assign enq = st_v_i & st_ready_o;
  assign deq = st_yumi_i & st_v_o;

  assign st_addr_o = addr_mem_q[rptr_q];
  assign st_size_o = size_mem_q[rptr_q];
  assign st_data_o = data_mem_q[rptr_q];

  // Replicate the valid low bytes across the dword so the LCE can drop the
  // payload onto any byte lane without knowing the offset.
  always_comb begin
    rep_data = st_data_i;
    case (st_size_i)
      2'd0:    rep_data = {8{st_data_i[7:0]}};
      2'd1:    rep_data = {4{st_data_i[15:0]}};
      2'd2:    rep_data = {2{st_data_i[31:0]}};
      default: rep_data = st_data_i;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (st_size_i)
      2'd0:    misaligned = 1'b0;
      2'd1:    misaligned = st_addr_i[0];
      2'd2:    misaligned = |st_addr_i[1:0];
      default: misaligned = |st_addr_i[2:0];
    endcase
  end

  always_comb begin
    rptr_d        = rptr_q + ptr_w'(deq);
    wptr_d        = wptr_q + ptr_w'(enq);
    count_d       = count_q + cnt_w'(enq) - cnt_w'(deq);
    outstanding_d = outstanding_q;
    // A send and a completion in the same cycle cancel out.
    if (deq && !credit_return_i)
      outstanding_d = outstanding_q + crd_w'(1);
    else if (!deq && credit_return_i && outstanding_q != '0)
      outstanding_d = outstanding_q - crd_w'(1);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_q        <= '0;
      wptr_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
    end else begin
      rptr_q        <= rptr_d;
      wptr_q        <= wptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Payload storage carries no reset; contents only matter while counted.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_mem_q[wptr_q] <= st_addr_i;
      size_mem_q[wptr_q] <= st_size_i;
      data_mem_q[wptr_q] <= rep_data;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(st_yumi_i && !st_v_o));
      assert (!(credit_return_i && !deq && outstanding_q == '0));
      assert (!(enq && misaligned));
    end
  end

endmodule

// File: tb/tb_bp_be_dcache_uc_store_buffer.sv
// Self-checking bench: directed vector table, corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_bp_be_dcache_uc_store_buffer;

  localparam int AW = 40;
  localparam int EL = 4;
  localparam int CR = 8;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          st_v_i;
  logic [AW-1:0] st_addr_i;
  logic [1:0]    st_size_i;
  logic [63:0]   st_data_i;
  logic          st_ready_o;
  logic          st_v_o;
  logic [AW-1:0] st_addr_o;
  logic [1:0]    st_size_o;
  logic [63:0]   st_data_o;
  logic          st_yumi_i;
  logic          credit_return_i;
  logic          full_o;
  logic          empty_o;

  always #5 clk = ~clk;

  bp_be_dcache_uc_store_buffer #(
    .paddr_width_p(AW), .dword_width_p(64), .els_p(EL), .credits_p(CR)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .st_v_i(st_v_i), .st_addr_i(st_addr_i), .st_size_i(st_size_i),
    .st_data_i(st_data_i), .st_ready_o(st_ready_o),
    .st_v_o(st_v_o), .st_addr_o(st_addr_o), .st_size_o(st_size_o),
    .st_data_o(st_data_o), .st_yumi_i(st_yumi_i),
    .credit_return_i(credit_return_i), .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [1:0]    s;
    logic [63:0]   d;
  } ent_t;

  typedef struct {
    logic          v;
    logic [AW-1:0] a;
    logic [1:0]    s;
    logic [63:0]   d;
    logic          y;
    logic          cr;
    logic          ev, erdy, efull, eemp, edc;
    logic [63:0]   ed;
  } vec_t;

  ent_t mq[$];
  int   mout;
  int   n_cmp = 0;
  int   n_err = 0;
  int   sent;
  vec_t tv[$];
  logic [63:0] emitted[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [1:0] s, input logic [63:0] d);
    case (s)
      2'd0:    return 64'(d[7:0])  * 64'h0101_0101_0101_0101;
      2'd1:    return 64'(d[15:0]) * 64'h0001_0001_0001_0001;
      2'd2:    return 64'(d[31:0]) * 64'h0000_0001_0000_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic model_v();
    return (mq.size() > 0) && (mout < CR);
  endfunction

  task automatic check_model();
    chk("v",     64'(st_v_o),     64'(model_v()));
    chk("ready", 64'(st_ready_o), 64'(mq.size() < EL));
    chk("full",  64'(full_o),     64'(mq.size() == EL));
    chk("empty", 64'(empty_o),    64'(mq.size() == 0 && mout == 0));
    if (mq.size() > 0) begin
      chk("head_addr", 64'(st_addr_o), 64'(mq[0].a));
      chk("head_size", 64'(st_size_o), 64'(mq[0].s));
      chk("head_data", st_data_o,      mq[0].d);
    end
  endtask

  // One clock: drive inputs, advance the model, compare after the edge.
  task automatic cyc(input logic v, input logic [AW-1:0] a, input logic [1:0] s,
                     input logic [63:0] d, input logic y, input logic cr);
    logic m_enq, m_deq;
    st_v_i = v; st_addr_i = a; st_size_i = s; st_data_i = d;
    st_yumi_i = y; credit_return_i = cr;
    m_enq = v && (mq.size() < EL);
    m_deq = y && model_v();
    if (m_deq) emitted.push_back(st_data_o);
    @(posedge clk); #1;
    if (m_deq) begin void'(mq.pop_front()); sent++; end
    if (m_enq) mq.push_back('{a, s, rep(s, d)});
    if (m_deq && !cr) mout++;
    else if (!m_deq && cr && mout > 0) mout--;
    st_v_i = 1'b0; st_yumi_i = 1'b0; credit_return_i = 1'b0;
    check_model();
  endtask

  task automatic do_reset();
    reset_i = 1'b1; credit_return_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0; credit_return_i = 1'b0;
    mq.delete(); mout = 0; sent = 0; emitted.delete();
    chk("rst_v",     64'(st_v_o),     64'd0);
    chk("rst_ready", 64'(st_ready_o), 64'd1);
    chk("rst_full",  64'(full_o),     64'd0);
    chk("rst_empty", 64'(empty_o),    64'd1);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [1:0]    rs;
    int            budget;
    reset_i = 1'b1; st_v_i = 1'b0; st_addr_i = '0; st_size_i = '0;
    st_data_i = '0; st_yumi_i = 1'b0; credit_return_i = 1'b0;
    mout = 0; sent = 0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table: single byte store, then fill / overflow / drain.
    //              v  addr            sz  data                     y  cr  ev rdy full emp dc  exp data
    tv.push_back('{1'b1, 40'h80000003, 2'd0, 64'hAB,                 1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'hABAB_ABAB_ABAB_ABAB});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0, 64'h0});
    tv.push_back('{1'b1, 40'h1000,     2'd1, 64'h1234,               1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'h1234_1234_1234_1234});
    tv.push_back('{1'b1, 40'h2004,     2'd2, 64'hDEADBEEF,           1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'h1234_1234_1234_1234});
    tv.push_back('{1'b1, 40'h3008,     2'd3, 64'h0123_4567_89AB_CDEF,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'h1234_1234_1234_1234});
    tv.push_back('{1'b1, 40'h4001,     2'd0, 64'h5A,                 1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1, 64'h1234_1234_1234_1234});
    tv.push_back('{1'b1, 40'h5000,     2'd3, 64'hFFFF_FFFF_FFFF_FFFF,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,1'b1, 64'h1234_1234_1234_1234});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'hDEAD_BEEF_DEAD_BEEF});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'h0123_4567_89AB_CDEF});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b1, 64'h5A5A_5A5A_5A5A_5A5A});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b1,1'b0, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b0,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 64'h0});
    tv.push_back('{1'b0, 40'h0,        2'd0, 64'h0,                  1'b0,1'b1, 1'b0,1'b1,1'b0,1'b1,1'b0, 64'h0});

    do_reset();
    for (int i = 0; i < tv.size(); i++) begin
      cyc(tv[i].v, tv[i].a, tv[i].s, tv[i].d, tv[i].y, tv[i].cr);
      chk($sformatf("tv%0d_v", i),     64'(st_v_o),     64'(tv[i].ev));
      chk($sformatf("tv%0d_ready", i), 64'(st_ready_o), 64'(tv[i].erdy));
      chk($sformatf("tv%0d_full", i),  64'(full_o),     64'(tv[i].efull));
      chk($sformatf("tv%0d_empty", i), 64'(empty_o),    64'(tv[i].eemp));
      if (tv[i].edc) chk($sformatf("tv%0d_data", i), st_data_o, tv[i].ed);
    end

    // Credit exhaustion: 8 sends without returns stalls a non-empty buffer.
    do_reset();
    budget = 0;
    while (sent < CR && budget < 60) begin
      cyc(1'b1, AW'(budget * 8), 2'd3, 64'(budget) + 64'hE000, model_v(), 1'b0);
      budget++;
    end
    chk("exhaust_sent", 64'(sent), 64'(CR));
    cyc(1'b0, '0, 2'd0, '0, 1'b0, 1'b0);
    chk("exhaust_v",     64'(st_v_o),  64'd0);
    chk("exhaust_empty", 64'(empty_o), 64'd0);
    cyc(1'b0, '0, 2'd0, '0, 1'b0, 1'b1);
    chk("credit_reenable_v", 64'(st_v_o), 64'd1);

    // Simultaneous enqueue + yumi + credit at count=2, outstanding=3.
    do_reset();
    cyc(1'b1, 40'h100, 2'd3, 64'hA0, 1'b0, 1'b0);
    cyc(1'b1, 40'h108, 2'd3, 64'hA1, 1'b1, 1'b0);
    cyc(1'b1, 40'h110, 2'd3, 64'hA2, 1'b1, 1'b0);
    cyc(1'b1, 40'h118, 2'd3, 64'hA3, 1'b1, 1'b0);
    cyc(1'b1, 40'h120, 2'd3, 64'hA4, 1'b0, 1'b0);
    cyc(1'b1, 40'h128, 2'd3, 64'hA5, 1'b1, 1'b1);
    chk("simul_head", st_data_o, 64'hA4);
    chk("simul_full", 64'(full_o), 64'd0);
    cyc(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 2'd0, '0, 1'b1, 1'b0);
    chk("simul_drained_v", 64'(st_v_o), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("simul_empty_pending", 64'(empty_o), 64'd0);
      cyc(1'b0, '0, 2'd0, '0, 1'b0, 1'b1);
    end
    chk("simul_empty_final", 64'(empty_o), 64'd1);

    // Wrap-around: 11 stores streamed with continuous yumi and credit return.
    do_reset();
    for (int k = 0; k <= 11; k++) begin
      cyc(k < 11, AW'(k * 8), 2'd3, 64'hC0DE_0000_0000_0000 | 64'(k), k > 0, mout > 0);
      if (k < 11) begin
        chk("wrap_v", 64'(st_v_o), 64'd1);
        chk("wrap_data", st_data_o, 64'hC0DE_0000_0000_0000 | 64'(k));
      end
    end
    chk("wrap_count", 64'(emitted.size()), 64'd11);
    for (int k = 0; k < emitted.size(); k++)
      chk("wrap_order", emitted[k], 64'hC0DE_0000_0000_0000 | 64'(k));

    // Reset mid-operation with 3 buffered and 5 outstanding.
    do_reset();
    budget = 0;
    while (!(sent >= 5 && mq.size() >= 3) && budget < 40) begin
      cyc(1'b1, AW'(budget * 8), 2'd3, 64'(budget), model_v() && sent < 5, 1'b0);
      budget++;
    end
    chk("midrst_setup_full", 64'(mq.size() == 3 && mout == 5), 64'd1);
    chk("midrst_pre_empty", 64'(empty_o), 64'd0);
    do_reset();
    cyc(1'b1, 40'h40, 2'd2, 64'h7777_8888, 1'b0, 1'b0);
    chk("post_rst_v", 64'(st_v_o), 64'd1);
    chk("post_rst_data", st_data_o, 64'h7777_8888_7777_8888);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rs = 2'($urandom_range(0, 3));
      ra = {8'($urandom), 32'($urandom)};
      ra = (ra >> rs) << rs;
      cyc(1'($urandom_range(0, 1)), ra, rs, {32'($urandom), 32'($urandom)},
          model_v() && ($urandom_range(0, 2) != 0),
          (mout > 0) && ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_be_dcache_uc_store_buffer.md
# bp_be_dcache_uc_store_buffer

Buffers uncached stores from the dcache so the pipeline does not stall on each one. Sits directly upstream of the dcache LCE request handler and presents one uncached-write payload at a time for it to pack into an `e_lce_req_type_uc_wr` request. Limits in-flight uncached writes with a credit counter that CCE completion returns replenish. Exports a drain indication so cached misses and uncached loads can be held until earlier stores complete.

## Interface
Parameters:
- paddr_width_p, 40, physical address width
- dword_width_p, 64, store data width; fixed at 64
- els_p, 4, buffer depth; power of two, at least 2
- credits_p, 8, maximum in-flight (sent, not yet completed) uncached writes

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset. One clock; reset is synchronous and active-high.
- st_v_i  in  1  uncached store valid
- st_addr_i  in  paddr_width_p  store address
- st_size_i  in  2  size: 0=1B, 1=2B, 2=4B, 3=8B
- st_data_i  in  64  store data; valid bytes in the LSBs
- st_ready_o  out  1  buffer can accept a store
- st_v_o  out  1  head entry valid and credit available
- st_addr_o  out  paddr_width_p  head address
- st_size_o  out  2  head size
- st_data_o  out  64  head data, replicated (see Operation)
- st_yumi_i  in  1  downstream consumed the head this cycle
- credit_return_i  in  1  one uncached write completed at the CCE
- full_o  out  1  count_r == els_p
- empty_o  out  1  count_r == 0 and outstanding_r == 0

## Operation
- Circular FIFO with a read pointer, a write pointer (log2(els_p) bits, natural wrap) and count_r (0..els_p).
- Enqueue when st_v_i & st_ready_o. Data is replicated at enqueue:
  - size 0: the low byte is copied to all 8 bytes
  - size 1: the low halfword is copied 4×
  - size 2: the low word is copied 2×
  - size 3: data passes through unchanged
- The address is stored unmodified.
- st_ready_o = (count_r != els_p). It does not depend on st_yumi_i, so there is no combinational path from yumi to ready. When full, a same-cycle dequeue does not allow a same-cycle enqueue.
- st_v_o = (count_r != 0) & (outstanding_r != credits_p).
- The head fields are driven from the read-pointer entry whenever count_r != 0. Their contents are don't-care when count_r == 0.
- Dequeue on st_yumi_i. st_yumi_i is legal only while st_v_o = 1. On dequeue, the read pointer advances and outstanding_r increments.
- outstanding_r (0..credits_p) decrements on credit_return_i.
  - A send and a credit_return_i in the same cycle leave it unchanged.
  - A credit_return_i with outstanding_r == 0 is a protocol error. The counter holds at 0 and a simulation assertion fires.
- Simultaneous enqueue and dequeue: count_r is unchanged and both pointers advance.
- empty_o stays low until every buffered store has been sent and acknowledged. Upstream uses it to order uncached loads and cached misses behind stores.
- Simulation-only assertions:
  - address misaligned for its size (low `size` bits nonzero)
  - st_yumi_i while st_v_o = 0
  - st_v_i while st_ready_o = 0 is not an error; the store is simply not taken

## Timing
- Reset values:
  - count_r, pointers, outstanding_r = 0
  - st_v_o = 0, full_o = 0, empty_o = 1, st_ready_o = 1
  - output payload is don't-care
- Reset asserted mid-operation discards all entries and in-flight credits on the next edge. Credit returns arriving during reset are ignored.
- Latency: a store enqueued at edge N appears on st_v_o in cycle N+1, provided a credit is available. There is no input-to-output bypass.
- Throughput: one enqueue and one dequeue per cycle.
- All outputs are functions of registered state only.
- The payload is held stable while st_v_o = 1 and st_yumi_i = 0.
- A credit returned at edge N can enable st_v_o in cycle N+1.

## Test plan
- **Single byte store.** After reset, enqueue addr=0x8000_0003, size=0, data=0xAB.
  - Next cycle: st_v_o=1, st_data_o=0xABAB_ABAB_ABAB_ABAB, empty_o=0.
  - Yumi it, then pulse credit_return_i: empty_o returns to 1.
- **Fill and overflow.** Enqueue 4 words with no yumi.
  - full_o=1 and st_ready_o=0 after the 4th.
  - A 5th st_v_i is not accepted.
  - Drain 4: the order matches the input and replication is correct for sizes 1 and 2 (e.g. 0x1234 → 0x1234_1234_1234_1234).
- **Credit exhaustion.** Run with credits_p=8 and no returns: after 8 yumis, st_v_o=0 even though count_r>0. One credit_return_i makes st_v_o=1 on the next cycle.
- **Simultaneous events.** Hold count_r=2 and outstanding_r=3; in one cycle assert enqueue, yumi and credit_return_i together. Result: count_r=2 and outstanding_r=3.
- **Wrap-around.** Stream 11 stores with continuous yumi and credit return. All 11 emerge in order with 1-cycle latency, and the pointers wrap without loss.
- **Reset mid-operation.** Hold 3 buffered entries and 5 outstanding, then assert reset_i for one cycle. Next cycle: st_v_o=0, empty_o=1, st_ready_o=1.
